// File: rtl/rh_seq_gen.sv
// rh_seq_gen: RowHammer command-sequence generator for the SoftMC instruction path.
// Each beat pairs a DDR command (slot0) with the WAIT that follows it (slot1);
// aggressor rows are activated round-robin for a programmable number of iterations.
//
// Instruction word layout:
//   [31:28] opcode
//   DDR command: [27] CKE, [26:25] CS (CS_WIDTH <= 2), [24] RAS_n, [23] CAS_n,
//                [22] WE_n, [21:19] bank, [18:0] address; write data sits in [18:11],
//                above the column bits, since writes always target column 0.
//   WAIT:        [27:0] cycle count
//   SET_BUSDIR:  [1:0] direction

`ifndef WAIT
`define WAIT 4'h1
`endif
`ifndef SET_BUSDIR
`define SET_BUSDIR 4'h2
`endif
`ifndef DDR_INSTR
`define DDR_INSTR 4'h8
`endif
`ifndef DEF_TRCD
`define DEF_TRCD 6
`endif
`ifndef DEF_TRAS
`define DEF_TRAS 15
`endif
`ifndef DEF_TRP
`define DEF_TRP 6
`endif

module rh_seq_gen #(
    parameter int CS_WIDTH  = 1,
    parameter int ROW_WIDTH = 15,
    parameter int NUM_AGGR  = 4,
    parameter int CNT_WIDTH = 24,
    parameter int T_RCD     = `DEF_TRCD,
    parameter int T_RAS     = `DEF_TRAS,
    parameter int T_RP      = `DEF_TRP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_AGGR*ROW_WIDTH-1:0] cfg_rows,
    input  logic [$clog2(NUM_AGGR):0]     cfg_num_rows,
    input  logic [2:0]                    cfg_bank,
    input  logic [CNT_WIDTH-1:0]          cfg_count,
    input  logic [7:0]                    cfg_pattern,
    input  logic [1:0]                    cfg_wmode,
    input  logic                          abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr0,
    output logic [31:0]                   out_instr1,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [CNT_WIDTH+2:0]          act_total
);

    localparam int NR_W  = $clog2(NUM_AGGR) + 1;
    localparam int IDX_W = (NUM_AGGR > 1) ? $clog2(NUM_AGGR) : 1;
    localparam int AT_W  = CNT_WIDTH + 3;
    localparam logic [CS_WIDTH-1:0] CS_ALL_LOW = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSDIR,
        S_ACT,
        S_WR,
        S_PRE,
        S_FIN
    } state_t;

    state_t                        state_q, state_d;
    logic [NUM_AGGR*ROW_WIDTH-1:0] rows_q, rows_d;
    logic [NR_W-1:0]               num_rows_q, num_rows_d;
    logic [2:0]                    bank_q, bank_d;
    logic [CNT_WIDTH-1:0]          count_q, count_d;
    logic [7:0]                    pattern_q, pattern_d;
    logic [1:0]                    wmode_q, wmode_d;
    logic [IDX_W-1:0]              row_idx_q, row_idx_d;
    logic [CNT_WIDTH-1:0]          iter_q, iter_d;
    logic                          out_valid_q, out_valid_d;
    logic [31:0]                   out_instr0_q, out_instr0_d;
    logic [31:0]                   out_instr1_q, out_instr1_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          aborted_q, aborted_d;
    logic [AT_W-1:0]               act_total_q, act_total_d;

    logic [ROW_WIDTH-1:0] row_arr [NUM_AGGR];
    logic [NR_W-1:0]      eff_rows;
    logic                 wrap;
    logic                 last_iter;
    logic [IDX_W-1:0]     act_idx;
    logic [CNT_WIDTH-1:0] act_iter;
    logic                 act_wr;
    logic [31:0]          act_beat0;
    logic [31:0]          act_beat1;
    logic [31:0]          wr_beat0;
    logic [31:0]          pre_beat0;

    for (genvar g = 0; g < NUM_AGGR; g++) begin : g_rows
        assign row_arr[g] = rows_q[g*ROW_WIDTH +: ROW_WIDTH];
    end

    function automatic logic [31:0] wait_instr(input int cycles);
        return {`WAIT, 28'(cycles)};
    endfunction

    function automatic logic [31:0] ddr_instr(input logic cke, input logic ras_n,
                                              input logic cas_n, input logic we_n,
                                              input logic [2:0] bank, input logic [18:0] addr);
        logic [31:0] w;
        w                  = '0;
        w[31:28]           = `DDR_INSTR;
        w[27]              = cke;
        w[25 +: CS_WIDTH]  = CS_ALL_LOW;
        w[24]              = ras_n;
        w[23]              = cas_n;
        w[22]              = we_n;
        w[21:19]           = bank;
        w[18:0]            = addr;
        return w;
    endfunction

    // Mode 3 deliberately falls through to "no write".
    function automatic logic act_writes(input logic [1:0] wm, input logic [CNT_WIDTH-1:0] it);
        return (wm == 2'd1) || ((wm == 2'd2) && (it == '0));
    endfunction

    // Effective row count, next-activation selection and the candidate beats.
    always_comb begin
        if (cfg_num_rows == '0) begin
            eff_rows = NR_W'(1);
        end else if (int'(cfg_num_rows) > NUM_AGGR) begin
            eff_rows = NR_W'(NUM_AGGR);
        end else begin
            eff_rows = cfg_num_rows;
        end

        wrap      = (NR_W'(row_idx_q) == (num_rows_q - NR_W'(1)));
        last_iter = (iter_q == (count_q - CNT_WIDTH'(1)));

        if (state_q == S_PRE) begin
            act_idx  = wrap ? '0 : (row_idx_q + IDX_W'(1));
            act_iter = wrap ? (iter_q + CNT_WIDTH'(1)) : iter_q;
        end else begin
            act_idx  = '0;
            act_iter = '0;
        end

        act_wr    = act_writes(wmode_q, act_iter);
        act_beat0 = ddr_instr(1'b1, 1'b0, 1'b1, 1'b1, bank_q, 19'(row_arr[act_idx]));
        act_beat1 = wait_instr(act_wr ? T_RCD : T_RAS);
        wr_beat0  = ddr_instr(1'b0, 1'b1, 1'b0, 1'b0, bank_q, {pattern_q, 11'b0});
        pre_beat0 = ddr_instr(1'b0, 1'b0, 1'b1, 1'b0, bank_q, 19'b0);
    end

    // Sequencer: each state presents one beat and moves on when it is accepted.
    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        num_rows_d   = num_rows_q;
        bank_d       = bank_q;
        count_d      = count_q;
        pattern_d    = pattern_q;
        wmode_d      = wmode_q;
        row_idx_d    = row_idx_q;
        iter_d       = iter_q;
        out_valid_d  = out_valid_q;
        out_instr0_d = out_instr0_q;
        out_instr1_d = out_instr1_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        act_total_d  = act_total_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d      = cfg_rows;
                    num_rows_d  = eff_rows;
                    bank_d      = cfg_bank;
                    count_d     = cfg_count;
                    pattern_d   = cfg_pattern;
                    wmode_d     = cfg_wmode;
                    row_idx_d   = '0;
                    iter_d      = '0;
                    act_total_d = '0;
                    aborted_d   = 1'b0;
                    if (cfg_count != '0) begin
                        state_d      = S_BUSDIR;
                        busy_d       = 1'b1;
                        out_valid_d  = 1'b1;
                        out_instr0_d = {`SET_BUSDIR, 26'b0, 2'b01};
                        out_instr1_d = wait_instr(1);
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_BUSDIR: begin
                if (out_ready) begin
                    state_d      = S_ACT;
                    out_instr0_d = act_beat0;
                    out_instr1_d = act_beat1;
                end
            end
            S_ACT: begin
                if (out_ready) begin
                    if (act_total_q != '1) begin
                        act_total_d = act_total_q + AT_W'(1);
                    end
                    if (act_writes(wmode_q, iter_q)) begin
                        state_d      = S_WR;
                        out_instr0_d = wr_beat0;
                        out_instr1_d = wait_instr(T_RAS - T_RCD);
                    end else begin
                        state_d      = S_PRE;
                        out_instr0_d = pre_beat0;
                        out_instr1_d = wait_instr(T_RP);
                    end
                end
            end
            S_WR: begin
                if (out_ready) begin
                    state_d      = S_PRE;
                    out_instr0_d = pre_beat0;
                    out_instr1_d = wait_instr(T_RP);
                end
            end
            S_PRE: begin
                if (out_ready) begin
                    if (abort || (wrap && last_iter)) begin
                        state_d      = S_FIN;
                        out_valid_d  = 1'b0;
                        out_instr0_d = '0;
                        out_instr1_d = '0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        aborted_d    = abort;
                    end else begin
                        state_d      = S_ACT;
                        row_idx_d    = act_idx;
                        iter_d       = act_iter;
                        out_instr0_d = act_beat0;
                        out_instr1_d = act_beat1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            num_rows_q   <= '0;
            bank_q       <= '0;
            count_q      <= '0;
            pattern_q    <= '0;
            wmode_q      <= '0;
            row_idx_q    <= '0;
            iter_q       <= '0;
            out_valid_q  <= 1'b0;
            out_instr0_q <= '0;
            out_instr1_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            act_total_q  <= '0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            num_rows_q   <= num_rows_d;
            bank_q       <= bank_d;
            count_q      <= count_d;
            pattern_q    <= pattern_d;
            wmode_q      <= wmode_d;
            row_idx_q    <= row_idx_d;
            iter_q       <= iter_d;
            out_valid_q  <= out_valid_d;
            out_instr0_q <= out_instr0_d;
            out_instr1_q <= out_instr1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            act_total_q  <= act_total_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr0 = out_instr0_q;
    assign out_instr1 = out_instr1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign act_total  = act_total_q;

endmodule

// File: tb/tb_rh_seq_gen.sv
// Testbench for rh_seq_gen: a beat-list model built from the sequencing rules is
// compared with the DUT every cycle, plus literal expectations for key beats.

module tb_rh_seq_gen;

    localparam int ROW_W  = 15;
    localparam int N_AGGR = 4;
    localparam int CNT_W  = 24;
    localparam int TRCD   = 6;
    localparam int TRAS   = 15;
    localparam int TRP    = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [N_AGGR*ROW_W-1:0]   cfg_rows;
    logic [2:0]                cfg_num_rows;
    logic [2:0]                cfg_bank;
    logic [CNT_W-1:0]          cfg_count;
    logic [7:0]                cfg_pattern;
    logic [1:0]                cfg_wmode;
    logic                      abort;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_instr0;
    logic [31:0]               out_instr1;
    logic                      busy;
    logic                      done;
    logic                      aborted;
    logic [CNT_W+2:0]          act_total;

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        bit          is_act;
        bit          is_pre;
    } beat_t;

    beat_t exp_q[$];
    beat_t acc_log[$];
    int    n_compared   = 0;
    int    n_mismatch   = 0;
    bit    check_en     = 0;
    bit    done_pending = 0;
    bit    pend_abort   = 0;
    bit    exp_aborted  = 0;
    int    exp_act      = 0;
    bit    stall_mode   = 0;

    rh_seq_gen #(
        .CS_WIDTH (1),
        .ROW_WIDTH(ROW_W),
        .NUM_AGGR (N_AGGR),
        .CNT_WIDTH(CNT_W),
        .T_RCD    (TRCD),
        .T_RAS    (TRAS),
        .T_RP     (TRP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_rows    (cfg_rows),
        .cfg_num_rows(cfg_num_rows),
        .cfg_bank    (cfg_bank),
        .cfg_count   (cfg_count),
        .cfg_pattern (cfg_pattern),
        .cfg_wmode   (cfg_wmode),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr0  (out_instr0),
        .out_instr1  (out_instr1),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .act_total   (act_total)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_wait(input int n);
        return 32'h1000_0000 | 32'(n);
    endfunction

    function automatic logic [31:0] enc_act(input int row, input int bank);
        return 32'h88C0_0000 | (32'(bank) << 19) | 32'(row);
    endfunction

    function automatic logic [31:0] enc_wr(input int bank, input int pat);
        return 32'h8100_0000 | (32'(bank) << 19) | (32'(pat) << 11);
    endfunction

    function automatic logic [31:0] enc_pre(input int bank);
        return 32'h8080_0000 | (32'(bank) << 19);
    endfunction

    function automatic logic [N_AGGR*ROW_W-1:0] pack_rows(input int a, input int b,
                                                          input int c, input int d);
        return {15'(d), 15'(c), 15'(b), 15'(a)};
    endfunction

    function automatic void push_beat(input logic [31:0] i0, input logic [31:0] i1,
                                      input bit is_act, input bit is_pre);
        beat_t b;
        b.i0 = i0;
        b.i1 = i1;
        b.is_act = is_act;
        b.is_pre = is_pre;
        exp_q.push_back(b);
    endfunction

    // Expected beat list for a whole run, straight from the sequencing rules.
    function automatic void build_model(input logic [N_AGGR*ROW_W-1:0] rows, input int num,
                                        input int bank, input int count, input int pat,
                                        input int wmode);
        int r_eff;
        logic [N_AGGR*ROW_W-1:0] sh;
        r_eff = (num == 0) ? 1 : ((num > N_AGGR) ? N_AGGR : num);
        exp_q.delete();
        if (count == 0) return;
        push_beat(32'h2000_0001, enc_wait(1), 0, 0);
        for (int it = 0; it < count; it++) begin
            for (int r = 0; r < r_eff; r++) begin
                bit w;
                w  = (wmode == 1) || ((wmode == 2) && (it == 0));
                sh = rows >> (r * ROW_W);
                push_beat(enc_act(int'(sh[ROW_W-1:0]), bank), enc_wait(w ? TRCD : TRAS), 1, 0);
                if (w) push_beat(enc_wr(bank, pat), enc_wait(TRAS - TRCD), 0, 0);
                push_beat(enc_pre(bank), enc_wait(TRP), 0, 1);
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start with a configuration, rebuild the model, optionally wait for completion.
    task automatic applyStimulus(input logic [N_AGGR*ROW_W-1:0] rows, input int num,
                                 input int bank, input int count, input int pat,
                                 input int wmode, input bit wait_done);
        cfg_rows     = rows;
        cfg_num_rows = 3'(num);
        cfg_bank     = 3'(bank);
        cfg_count    = CNT_W'(count);
        cfg_pattern  = 8'(pat);
        cfg_wmode    = 2'(wmode);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_log.delete();
        build_model(rows, num, bank, count, pat, wmode);
        exp_act      = 0;
        exp_aborted  = 0;
        pend_abort   = 0;
        done_pending = (count == 0);
        if (wait_done) begin
            for (int c = 0; c < 3000; c++) begin
                if (exp_q.size() == 0 && !done_pending) break;
                @(posedge clk);
                #1;
            end
            checkOutput("run_complete", 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_instr0"}, 64'(out_instr0), 64'd0);
        checkOutput({tag, "_instr1"}, 64'(out_instr1), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_aborted"}, 64'(aborted), 64'd0);
        checkOutput({tag, "_act_total"}, 64'(act_total), 64'd0);
    endtask

    // Ready generator: always high, or random stalls when stall_mode is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        cfg_rows     = '0;
        cfg_num_rows = '0;
        cfg_bank     = '0;
        cfg_count    = '0;
        cfg_pattern  = '0;
        cfg_wmode    = '0;
        fork
            // Per-cycle compare against the model, sampled on the falling edge.
            forever begin
                @(negedge clk);
                if (check_en) begin
                    checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                    checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
                    if (done_pending) exp_aborted = pend_abort;
                    checkOutput("done", 64'(done), 64'(done_pending));
                    checkOutput("aborted", 64'(aborted), 64'(exp_aborted));
                    checkOutput("act_total", 64'(act_total), 64'(exp_act));
                    done_pending = 0;
                    if (out_valid && exp_q.size() != 0) begin
                        checkOutput("slot0", 64'(out_instr0), 64'(exp_q[0].i0));
                        checkOutput("slot1", 64'(out_instr1), 64'(exp_q[0].i1));
                        if (out_ready) begin
                            beat_t cur;
                            cur = exp_q.pop_front();
                            acc_log.push_back(cur);
                            if (cur.is_act) exp_act++;
                            if (cur.is_pre && abort) begin
                                exp_q.delete();
                                pend_abort = 1;
                            end
                            if (exp_q.size() == 0) done_pending = 1;
                        end
                    end
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_reset_values("reset");
                rst = 1'b0;
                check_en = 1;
                @(posedge clk);
                #1;

                // Two rows, no writes.
                applyStimulus(pack_rows(100, 102, 0, 0), 2, 3, 3, 0, 0, 1);
                checkOutput("t1_beats", 64'(acc_log.size()), 64'd13);
                checkOutput("t1_busdir", 64'(acc_log[0].i0), 64'h2000_0001);
                checkOutput("t1_busdir_wait", 64'(acc_log[0].i1), 64'h1000_0001);
                checkOutput("t1_act0", 64'(acc_log[1].i0), 64'h88D8_0064);
                checkOutput("t1_act0_wait", 64'(acc_log[1].i1), 64'h1000_000F);
                checkOutput("t1_pre0", 64'(acc_log[2].i0), 64'h8098_0000);
                checkOutput("t1_pre0_wait", 64'(acc_log[2].i1), 64'h1000_0004);
                checkOutput("t1_act1", 64'(acc_log[3].i0), 64'h88D8_0066);
                checkOutput("t1_act_total", 64'(act_total), 64'd6);

                // Write on first iteration only.
                applyStimulus(pack_rows(100, 0, 0, 0), 1, 3, 2, 8'hA5, 2, 1);
                checkOutput("t2_beats", 64'(acc_log.size()), 64'd6);
                checkOutput("t2_act0_wait", 64'(acc_log[1].i1), 64'h1000_0006);
                checkOutput("t2_wr", 64'(acc_log[2].i0), 64'h811D_2800);
                checkOutput("t2_wr_wait", 64'(acc_log[2].i1), 64'h1000_0009);
                checkOutput("t2_act1_wait", 64'(acc_log[4].i1), 64'h1000_000F);

                // Random stalls, four rows, write every activation; start while busy ignored.
                stall_mode = 1;
                fork
                    applyStimulus(pack_rows(10, 20, 30, 40), 4, 5, 5, 8'h3C, 1, 1);
                    begin
                        repeat (12) @(posedge clk);
                        #1;
                        cfg_rows     = '1;
                        cfg_num_rows = 3'd1;
                        cfg_bank     = 3'd0;
                        cfg_count    = CNT_W'(1);
                        cfg_wmode    = 2'd0;
                        start        = 1'b1;
                        @(posedge clk);
                        #1;
                        start = 1'b0;
                    end
                join
                stall_mode = 0;
                @(posedge clk);
                #1;
                checkOutput("t3_beats", 64'(acc_log.size()), 64'd61);
                checkOutput("t3_act_row1", 64'(acc_log[4].i0), 64'h88E8_0014);
                checkOutput("t3_act_total", 64'(act_total), 64'd20);

                // Abort raised while the second WR beat is presented.
                fork
                    applyStimulus(pack_rows(100, 0, 0, 0), 1, 3, 10, 8'h5A, 1, 1);
                    begin
                        int wr_seen;
                        wr_seen = 0;
                        for (int c = 0; c < 200 && abort == 1'b0; c++) begin
                            @(posedge clk);
                            #1;
                            if (out_valid && out_instr0 == enc_wr(3, 8'h5A)) begin
                                wr_seen++;
                                if (wr_seen == 2) abort = 1'b1;
                            end
                        end
                    end
                join
                checkOutput("t4_beats", 64'(acc_log.size()), 64'd7);
                checkOutput("t4_last_pre", 64'(acc_log[6].i0), 64'h8098_0000);
                checkOutput("t4_aborted", 64'(aborted), 64'd1);
                checkOutput("t4_act_total", 64'(act_total), 64'd2);

                // Zero count, with abort held high: no beats, not aborted.
                applyStimulus(pack_rows(1, 2, 3, 4), 2, 1, 0, 0, 1, 1);
                abort = 1'b0;
                checkOutput("t5_beats", 64'(acc_log.size()), 64'd0);
                checkOutput("t5_aborted", 64'(aborted), 64'd0);

                // Row count 0 behaves as 1; 7 clamps to 4.
                applyStimulus(pack_rows(7, 8, 9, 10), 0, 1, 2, 0, 0, 1);
                checkOutput("t6_beats", 64'(acc_log.size()), 64'd5);
                checkOutput("t6_act_again", 64'(acc_log[3].i0), 64'h88C8_0007);
                applyStimulus(pack_rows(1, 2, 3, 4), 7, 1, 1, 0, 0, 1);
                checkOutput("t7_beats", 64'(acc_log.size()), 64'd9);
                checkOutput("t7_act_row3", 64'(acc_log[7].i0), 64'h88C8_0004);

                // Reset while an ACT beat is presented.
                begin
                    bit found;
                    found = 0;
                    applyStimulus(pack_rows(100, 102, 0, 0), 2, 3, 3, 0, 0, 0);
                    for (int c = 0; c < 20; c++) begin
                        if (out_valid && out_instr0 == enc_act(100, 3)) begin
                            found = 1;
                            break;
                        end
                        @(posedge clk);
                        #1;
                    end
                    checkOutput("t8_act_seen", 64'(found), 64'd1);
                    check_en = 0;
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    check_reset_values("midrst");
                    rst = 1'b0;
                    exp_q.delete();
                    done_pending = 0;
                    pend_abort   = 0;
                    exp_aborted  = 0;
                    exp_act      = 0;
                    check_en     = 1;
                    @(posedge clk);
                    #1;
                end
                applyStimulus(pack_rows(55, 0, 0, 0), 1, 2, 1, 8'h11, 1, 1);
                checkOutput("t9_beats", 64'(acc_log.size()), 64'd4);

                repeat (2) @(posedge clk);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
                $finish;
            end
        join
    end

endmodule

// File: doc/rh_seq_gen.md
# rh_seq_gen

Parametrised RowHammer command-sequence generator for the SoftMC instruction path. It hammers up to NUM_AGGR aggressor rows in round-robin order, with a configurable activation count, bank and write mode, and an optional early abort. It emits one two-slot instruction beat per handshake: slot0 carries a DDR command and slot1 carries the matching WAIT. It sits between the host-side instruction decoder and the two-slot instruction dispatcher.

## Interface
- CS_WIDTH, 1: chip-select field width.
- ROW_WIDTH, 15: row address width.
- NUM_AGGR, 4: maximum aggressor rows.
- CNT_WIDTH, 24: width of the activation counter.
- T_RCD, `DEF_TRCD: WAIT cycles after ACT when writing.
- T_RAS, `DEF_TRAS: ACT-to-PRE cycles.
- T_RP, `DEF_TRP: WAIT cycles after PRE.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; accepted only while busy=0.
- cfg_rows  in  NUM_AGGR*ROW_WIDTH  packed aggressor rows; row i is at [i*ROW_WIDTH +: ROW_WIDTH].
- cfg_num_rows  in  clog2(NUM_AGGR)+1  rows used. 0 is treated as 1; values above NUM_AGGR are clamped to NUM_AGGR.
- cfg_bank  in  3  bank for every ACT/WR/PRE.
- cfg_count  in  CNT_WIDTH  hammer iterations; each iteration activates every used row once.
- cfg_pattern  in  8  write data pattern.
- cfg_wmode  in  2  write mode: 0 = none, 1 = write every activation, 2 = write on first iteration only, 3 = treated as 0.
- abort  in  1  level; requests an early stop.
- out_valid  out  1  beat available.
- out_ready  in  1  dispatcher accepts the beat.
- out_instr0  out  32  command slot.
- out_instr1  out  32  WAIT slot.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  done was caused by abort; held until the next start.
- act_total  out  CNT_WIDTH+3  ACT beats accepted in the current or last run.

## Operation
- All config is latched on the accepted start. Config inputs are ignored while busy.
- FSM states: IDLE, BUSDIR, ACT, WR, PRE, FIN.
- IDLE:
  - On start with cfg_count≠0, go to BUSDIR.
  - On start with cfg_count=0, go to FIN with no beats.
- BUSDIR beat:
  - slot0 = `SET_BUSDIR with [1:0]=2'b01.
  - slot1 = `WAIT, count 1.
  - Next state is ACT.
- ACT beat:
  - slot0 = `DDR_INSTR with CKE=1, CS=0 (all bits), RAS=0, CAS=1, WE=1.
  - Row address field = cfg_rows[row_idx]; bank field = cfg_bank.
  - slot1 = `WAIT with T_RCD if this activation writes, otherwise T_RAS.
  - Next state is WR if writing, otherwise PRE.
- WR beat:
  - slot0 = `DDR_INSTR with RAS=1, CAS=0, WE=1→0 per write encoding (WE=0), column 0, A10=0, bank field.
  - Pattern is placed in the codebase write-data field.
  - slot1 = `WAIT, T_RAS−T_RCD.
  - Next state is PRE.
- PRE beat:
  - slot0 = `DDR_INSTR with RAS=0, CAS=1, WE=0, A10=0, bank field.
  - slot1 = `WAIT, T_RP.
- On PRE acceptance:
  - If abort=1, or this is the last row of the last iteration, go to FIN.
  - Otherwise advance row_idx; on wrap to 0, increment the iteration counter. Then go to ACT.
- Writing decision per activation:
  - wmode 1: always.
  - wmode 2: only while the iteration counter is 0.
- Abort behaviour:
  - Sampled only on PRE acceptance, so an opened row is always precharged.
  - Abort during BUSDIR or IDLE has no effect.
- FIN: pulse done and clear busy; set aborted if the stop came from abort; go to IDLE.
- Instruction bits not listed above are 0.
- act_total:
  - Clears on start.
  - Increments on each accepted ACT beat.
  - Saturates at all-ones.

## Timing
- Reset values: out_valid=0, out_instr0/1=0, busy=0, done=0, aborted=0, act_total=0, state=IDLE.
- Start accepted at cycle N:
  - busy=1 at N+1.
  - out_valid=1 with the BUSDIR beat at N+1.
- Handshake:
  - A beat transfers on the cycle where out_valid & out_ready.
  - Until transfer, out_valid and both slots are held stable.
  - The next beat is valid the following cycle, giving one beat per cycle with out_ready held high.
- Completion:
  - done is high, and busy goes low, in the cycle after the final PRE is accepted.
  - start is accepted again in the cycle after done.
  - With cfg_count=0, done fires at N+1 and out_valid never rises.
- Total beats = 1 + cfg_count·R·(2 + W), where R is the effective row count and W is 1 for a writing activation.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values; the open row is not precharged.

## Test plan
- R=2, rows {100,102}, count=3, wmode=0, out_ready=1 → 13 beats: BUSDIR, then ACT100/PRE, ACT102/PRE ×3. ACT waits = T_RAS. done on the cycle after the 13th beat; act_total=6.
- R=1, count=2, wmode=2, pattern 8'hA5 → beats BUSDIR, ACT, WR, PRE, ACT, PRE. First ACT wait = T_RCD, second = T_RAS.
- Random out_ready stalls, R=4, count=5, wmode=1 → slots stable across every stall, 61 beats, row order 0,1,2,3 repeating.
- abort raised during the second WR beat, count=10 → the PRE for that row is still emitted, then done with aborted=1 and act_total=2.
- cfg_count=0 → done at N+1, no out_valid. cfg_num_rows=0 → behaves as 1. cfg_num_rows=7 with NUM_AGGR=4 → clamped to 4.
- start asserted while busy → ignored, latched config unchanged. rst asserted mid-ACT → all outputs return to reset values next cycle.
